// File: rtl/o_buf_controller_pkg.sv
// -----------------------------------------------------------------------------
// o_buf_controller_pkg
// Shared definitions for the output line-buffer reader:
//   - obuf_state_e     : controller state encoding (IDLE, FETCH, DRAIN)
//   - PIXELS_PER_WORD  : 8-bit pixels packed into one 32-bit linebuffer word
//   - byte_lane()      : selects one pixel lane out of a packed word
// -----------------------------------------------------------------------------
package o_buf_controller_pkg;

    localparam int PIXELS_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } obuf_state_e;

    // Pixel 0 lives in [7:0], pixel 3 in [31:24].
    function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                             input logic [1:0]  lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/o_buf_word_fifo.sv
// -----------------------------------------------------------------------------
// o_buf_word_fifo
// Two-entry 32-bit word FIFO sitting between the linebuffer read port and the
// pixel unpacker.
// Ports:
//   clk_i        clock, rising edge
//   srst_i       synchronous active-high reset (empties the FIFO)
//   push_i       write push_data_i (ignored when full)
//   push_data_i  word to write
//   pop_i        drop the head word (ignored when empty)
//   count_o      current occupancy, 0..2
//   head_o       oldest word; stays stable until popped
// -----------------------------------------------------------------------------
module o_buf_word_fifo (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic [31:0] head_o
);

    logic [31:0] mem_q [0:1];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        do_push;
    logic        do_pop;

    assign do_push = push_i && (count_q != 2'd2);
    assign do_pop  = pop_i  && (count_q != 2'd0);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/o_buf_controller.sv
// -----------------------------------------------------------------------------
// o_buf_controller
// Reads a completed line back from the ping-pong linebuffer (one 32-bit word
// per read), unpacks each word into four 8-bit pixels and streams them out on
// a valid/ready interface with start-of-frame and end-of-line markers.
//
// Ports:
//   pclk         pixel clock, rising edge
//   reset        synchronous active-high reset
//   line_valid   pulse: a line is complete in the writer's current bank
//   frame_valid  pulse: frame complete, next line is start-of-frame
//   rd_en        linebuffer read strobe
//   rd_addr      linebuffer word address (bank*LINE_WORDS + word index)
//   rd_data      read data, valid the cycle after rd_en
//   px_data      pixel value
//   px_valid     pixel valid
//   px_ready     downstream ready
//   px_sof       marks the first pixel of a frame
//   px_eol       marks the last pixel of a line
//   busy         a line is being fetched or drained
//   overrun      sticky: a line arrived while one was already pending
//   test_mode    (only with O_BUF_TEST_PATTERN_EN) generate a ramp pattern
//                instead of reading the linebuffer for lines started with it set
//
// Optional feature macro: O_BUF_TEST_PATTERN_EN
// -----------------------------------------------------------------------------
module o_buf_controller
    import o_buf_controller_pkg::*;
#(
    parameter  int LINE_PIXELS = 640,
    localparam int LINE_WORDS  = LINE_PIXELS / PIXELS_PER_WORD
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        line_valid,
    input  logic        frame_valid,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        px_sof,
    output logic        px_eol,
`ifdef O_BUF_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic        busy,
    output logic        overrun
);

    localparam int WIDX_W = $clog2(LINE_WORDS) + 1;
    localparam int PIDX_W = $clog2(LINE_PIXELS) + 1;

    obuf_state_e       state_q, state_d;
    logic              bank_q, bank_d;
    logic              pending_q, pending_d;
    logic              sof_next_q, sof_next_d;
    logic              overrun_q, overrun_d;
    logic              inflight_q;
    logic              test_q;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [PIDX_W-1:0] px_idx_q, px_idx_d;

    logic [1:0]        fifo_count;
    logic [31:0]       fifo_head;
    logic              rd_window_ok;
    logic              xfer;
    logic              last_px;
    logic              fifo_pop;

    // The word returned for a read is pushed the cycle after rd_en, which is
    // exactly when inflight_q is high. Clearing inflight_q on reset is what
    // discards a read that was outstanding when the line was aborted.
    o_buf_word_fifo u_word_fifo (
        .clk_i       (pclk),
        .srst_i      (reset),
        .push_i      (inflight_q),
        .push_data_i (rd_data),
        .pop_i       (fifo_pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    // Only issue a read if its data is guaranteed a free FIFO slot, counting
    // the read that is still in flight.
    assign rd_window_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2;
    assign rd_en        = (state_q == ST_FETCH) && rd_window_ok;
    assign rd_addr      = rd_en ? ((bank_q ? 32'(LINE_WORDS) : 32'd0) + 32'(word_idx_q))
                                : 32'd0;

    // Pixel index within the line; its two LSBs are the byte lane.
    assign last_px  = (px_idx_q == PIDX_W'(LINE_PIXELS - 1));
    assign px_valid = test_q ? (state_q == ST_DRAIN) : (fifo_count != 2'd0);
    assign xfer     = px_valid && px_ready;
    assign fifo_pop = xfer && !test_q && (px_idx_q[1:0] == 2'b11);

    assign px_data  = !px_valid ? 8'h00 :
                      test_q    ? (8'(px_idx_q) ^ {7'b0, bank_q}) :
                                  byte_lane(fifo_head, px_idx_q[1:0]);
    assign px_sof   = px_valid && sof_next_q && (px_idx_q == '0);
    assign px_eol   = px_valid && last_px;
    assign busy     = (state_q != ST_IDLE);
    assign overrun  = overrun_q;

`ifdef O_BUF_TEST_PATTERN_EN
    logic test_d;

    always_ff @(posedge pclk) begin
        if (reset) begin
            test_q <= 1'b0;
        end else begin
            test_q <= test_d;
        end
    end
`else
    assign test_q = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        pending_d  = pending_q;
        sof_next_d = sof_next_q;
        overrun_d  = overrun_q;
        word_idx_d = word_idx_q;
        px_idx_d   = px_idx_q;
`ifdef O_BUF_TEST_PATTERN_EN
        test_d     = test_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (line_valid || pending_q) begin
                    // A pending line is served first; a line_valid arriving
                    // in the same cycle becomes the new pending line.
                    pending_d  = pending_q && line_valid;
                    word_idx_d = '0;
                    state_d    = ST_FETCH;
`ifdef O_BUF_TEST_PATTERN_EN
                    test_d     = test_mode;
                    if (test_mode) begin
                        state_d = ST_DRAIN;
                    end
`endif
                end
            end
            ST_FETCH: begin
                if (rd_en) begin
                    if (word_idx_q == WIDX_W'(LINE_WORDS - 1)) begin
                        word_idx_d = '0;
                        state_d    = ST_DRAIN;
                    end else begin
                        word_idx_d = word_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // The last pixel pops the last word, so the FIFO is empty
                // once it transfers.
                if (xfer && last_px) begin
                    bank_d  = ~bank_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Lines arriving while busy (including the final-pixel cycle) queue
        // one deep; anything beyond that is dropped and flagged.
        if ((state_q != ST_IDLE) && line_valid) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (xfer) begin
            px_idx_d = last_px ? '0 : px_idx_q + 1'b1;
        end

        if (xfer && px_sof) begin
            sof_next_d = 1'b0;
        end
        if (frame_valid) begin
            sof_next_d = 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bank_q     <= 1'b0;
            pending_q  <= 1'b0;
            sof_next_q <= 1'b1;
            overrun_q  <= 1'b0;
            inflight_q <= 1'b0;
            word_idx_q <= '0;
            px_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            bank_q     <= bank_d;
            pending_q  <= pending_d;
            sof_next_q <= sof_next_d;
            overrun_q  <= overrun_d;
            inflight_q <= rd_en;
            word_idx_q <= word_idx_d;
            px_idx_q   <= px_idx_d;
        end
    end

endmodule

// File: tb/tb_o_buf_controller.sv
// -----------------------------------------------------------------------------
// tb_o_buf_controller
// Randomized and directed stimulus against a line-level reference model:
// every accepted line expands into its expected read addresses and pixel
// stream (taken straight from the linebuffer contents), which are compared
// with what the controller produces.
// -----------------------------------------------------------------------------
module tb_o_buf_controller;

    localparam int LP = 8;
    localparam int LW = LP / 4;

    logic        pclk = 1'b0;
    logic        reset;
    logic        line_valid;
    logic        frame_valid;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  px_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_sof;
    logic        px_eol;
    logic        busy;
    logic        overrun;
    logic        test_mode = 1'b0;

    always #5 pclk = ~pclk;

    o_buf_controller #(.LINE_PIXELS(LP)) dut (
        .pclk        (pclk),
        .reset       (reset),
        .line_valid  (line_valid),
        .frame_valid (frame_valid),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .px_data     (px_data),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_sof      (px_sof),
        .px_eol      (px_eol),
`ifdef O_BUF_TEST_PATTERN_EN
        .test_mode   (test_mode),
`endif
        .busy        (busy),
        .overrun     (overrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, exp);
        end
    endtask

    // Linebuffer read port: data for an rd_en appears one cycle later;
    // any other cycle carries random garbage.
    logic [31:0] lb_mem [0:2*LW-1];

    always @(posedge pclk) begin
        rd_data <= rd_en ? lb_mem[int'(rd_addr % 32'(2*LW))] : $urandom();
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] d;
        logic       first;
        logic       eol;
        logic       word_end;
    } px_t;

    px_t         exp_q[$];
    logic [31:0] addr_q[$];
    bit          m_active, m_pend, m_bank, m_sof, m_ovr, st_valid;
    int          issued, consumed, xfers, lines_done;

    task automatic accept_line();
        for (int k = 0; k < LW; k++) begin
            if (!test_mode) addr_q.push_back(32'(m_bank) * LW + 32'(k));
        end
        for (int p = 0; p < LP; p++) begin
            logic [31:0] w;
            px_t e;
            w          = lb_mem[int'(m_bank) * LW + p / 4];
            e.d        = test_mode ? (8'(p) ^ {7'b0, m_bank}) : w[8*(p%4) +: 8];
            e.first    = (p == 0);
            e.eol      = (p == LP - 1);
            e.word_end = !test_mode && (p % 4 == 3);
            exp_q.push_back(e);
        end
        m_bank = ~m_bank;
    endtask

    always @(negedge pclk) begin
        if (reset) begin
            exp_q.delete();
            addr_q.delete();
            m_active = 0; m_pend = 0; m_bank = 0; m_sof = 1; m_ovr = 0;
            st_valid = 0; issued = 0; consumed = 0;
        end else begin
            check("overrun", overrun, m_ovr);
            // A line_valid is judged against the state before any completion
            // in the same cycle.
            if (line_valid) begin
                if (!m_active) begin
                    m_active = 1; accept_line();
                end else if (!m_pend) begin
                    m_pend = 1; accept_line();
                end else begin
                    m_ovr = 1;
                end
            end
            if (rd_en) begin
                check("rd_expected", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("rd_addr", rd_addr, addr_q.pop_front());
                check("rd_window", (issued - consumed) < 2, 1);
                issued++;
            end
            if (st_valid) check("bp_valid_hold", px_valid, 1);
            if (px_valid) begin
                check("px_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    px_t e;
                    e = exp_q[0];
                    check("px_data", px_data, e.d);
                    check("px_eol", px_eol, e.eol);
                    check("px_sof", px_sof, e.first && m_sof);
                    if (px_ready) begin
                        void'(exp_q.pop_front());
                        xfers++;
                        if (e.first && m_sof) m_sof = 0;
                        if (e.word_end) consumed++;
                        if (e.eol) begin
                            lines_done++;
                            $display("line %0d done (pending=%0d overrun=%0d)", lines_done, m_pend, m_ovr);
                            if (m_pend) m_pend = 0;
                            else        m_active = 0;
                        end
                    end
                end
            end
            st_valid = px_valid && !px_ready;
            if (frame_valid) m_sof = 1;
        end
    end

    // ---------------- stimulus helpers ----------------
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held by caller

    task automatic step();
        @(posedge pclk);
        #1;
        line_valid  = 1'b0;
        frame_valid = 1'b0;
        if (ready_mode == 1)      px_ready = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 0) px_ready = 1'b1;
    endtask

    task automatic pulse(input logic lv, input logic fv);
        line_valid  = lv;
        frame_valid = fv;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("idle_timeout", n < budget, 1);
        repeat (2) step();
    endtask

    task automatic wait_xfers(input int target);
        int g;
        g = 0;
        while (xfers < target && g < 60) begin
            step();
            g++;
        end
        check("xfer_wait", xfers >= target, 1);
    endtask

    task automatic check_outputs_zero();
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_px_data", px_data, 0);
        check("rst_px_valid", px_valid, 0);
        check("rst_px_sof", px_sof, 0);
        check("rst_px_eol", px_eol, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
    endtask

    task automatic rand_mem();
        for (int i = 0; i < 2 * LW; i++) lb_mem[i] = $urandom();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int lat;
        reset = 1'b1; line_valid = 1'b0; frame_valid = 1'b0; px_ready = 1'b1;
        rand_mem();
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;
        check_outputs_zero();

        // Single line: known words, latency and first pixel.
        lb_mem[0] = 32'h44332211;
        lb_mem[1] = 32'h88776655;
        line_valid = 1'b1;
        step();
        check("rd_en_latency", rd_en, 1);
        check("rd_addr_first", rd_addr, 0);
        lat = 1;
        while (!px_valid && lat < 10) begin
            step();
            lat++;
        end
        check("first_px_latency", lat, 3);
        check("first_px_data", px_data, 8'h11);
        check("first_px_sof", px_sof, 1);
        wait_idle(100);

        // Backpressure mid-word for 5 cycles.
        pulse(1, 0);
        wait_xfers(xfers + 2);
        ready_mode = 2;
        px_ready   = 1'b0;
        repeat (5) step();
        check("bp_valid_after_stall", px_valid, 1);
        ready_mode = 0;
        px_ready   = 1'b1;
        wait_idle(200);

        // Three extra lines during one busy line: one pending, rest dropped.
        pulse(1, 0);
        step();
        pulse(1, 0);
        pulse(1, 0);
        pulse(1, 0);
        wait_idle(300);
        check("overrun_sticky", overrun, 1);

        // Reset after three pixels of a line.
        rand_mem();
        pulse(1, 0);
        wait_xfers(xfers + 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_outputs_zero();

        // Ping-pong and SOF: frame with first line, second line pending.
        pulse(1, 1);
        repeat (3) step();
        pulse(1, 0);
        wait_idle(300);

`ifdef O_BUF_TEST_PATTERN_EN
        if (m_bank == 1'b0) begin
            pulse(1, 0);
            wait_idle(200);
        end
        test_mode = 1'b1;
        pulse(1, 0);
        wait_idle(200);
        test_mode = 1'b0;
`endif

        // Random traffic with random backpressure.
        rand_mem();
        ready_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            line_valid  = ($urandom_range(0, 15) == 0);
            frame_valid = ($urandom_range(0, 31) == 0);
            step();
        end
        ready_mode = 0;
        wait_idle(500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
